// File: rtl/clk_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl_if
// Description : Control/status bundle for the programmable clock divider.
//               The master side drives the run and ratio-update requests.
//               The slave side (the divider) returns handshake and clock
//               outputs.
// Signals     : i_enable       run request, level sensitive
//               i_div_ratio    requested ratio N (DIV_W bits)
//               i_cfg_req      ratio update request
//               o_cfg_ack      one-cycle pulse when the new ratio is active
//               o_busy         ratio update pending
//               o_clk_div_out  divided clock
//               o_tick         one-cycle pulse on each divided rising edge
//               o_edge_cnt     16-bit tick count (CLK_DIV_EDGE_CNT_EN only)
// Options     : CLK_DIV_EDGE_CNT_EN adds o_edge_cnt
// Revision    : 1.0  initial release
// ============================================================================
interface clk_div_ctrl_if #(
   parameter int DIV_W = 8
) ();
   logic             i_enable;
   logic [DIV_W-1:0] i_div_ratio;
   logic             i_cfg_req;
   logic             o_cfg_ack;
   logic             o_busy;
   logic             o_clk_div_out;
   logic             o_tick;
`ifdef CLK_DIV_EDGE_CNT_EN
   logic [15:0]      o_edge_cnt;
`endif

`ifdef CLK_DIV_EDGE_CNT_EN
   modport master (
      output i_enable, i_div_ratio, i_cfg_req,
      input  o_cfg_ack, o_busy, o_clk_div_out, o_tick, o_edge_cnt
   );
   modport slave (
      input  i_enable, i_div_ratio, i_cfg_req,
      output o_cfg_ack, o_busy, o_clk_div_out, o_tick, o_edge_cnt
   );
`else
   modport master (
      output i_enable, i_div_ratio, i_cfg_req,
      input  o_cfg_ack, o_busy, o_clk_div_out, o_tick
   );
   modport slave (
      input  i_enable, i_div_ratio, i_cfg_req,
      output o_cfg_ack, o_busy, o_clk_div_out, o_tick
   );
`endif
endinterface
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Programmable clock-divider controller. It produces a
//               registered divided clock plus a one-cycle tick on every
//               divided rising edge. Ratio updates use a req/ack handshake
//               and only take effect at a period boundary, so the output
//               never carries a runt pulse.
//               Waveform for ratio N: high floor(N/2) cycles, then low
//               N-floor(N/2) cycles.
// Ports       : clk     master clock
//               reset   asynchronous reset, active high
//               io_bus  clk_div_ctrl_if.slave control/status bundle
// Parameters  : DIV_W        ratio / period counter width
//               DEFAULT_DIV  ratio active after reset (>= 2)
// Options     : CLK_DIV_EDGE_CNT_EN enables a 16-bit wrapping tick counter
//               on io_bus.o_edge_cnt
// Revision    : 1.0  initial release
// ============================================================================
module clk_div_ctrl #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic           clk,
   input  logic           reset,
   clk_div_ctrl_if.slave  io_bus
);

   localparam logic [DIV_W-1:0] c_DEFAULT_DIV = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] c_MIN_DIV     = DIV_W'(2);
   localparam logic [DIV_W-1:0] c_ONE         = DIV_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PEND = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DIV_W-1:0] r_n;
   logic [DIV_W-1:0] w_n_nxt;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] w_cnt_nxt;
   logic [DIV_W-1:0] r_shadow;
   logic [DIV_W-1:0] w_shadow_nxt;
   logic             r_out;
   logic             w_out_nxt;
   logic             r_tick;
   logic             w_tick_nxt;
   logic             r_ack;
   logic             w_ack_nxt;
   logic             r_busy;
   logic             w_busy_nxt;

   logic [DIV_W-1:0] w_req_ratio;
   logic [DIV_W-1:0] w_half;
   logic [DIV_W-1:0] w_cnt_inc;
   logic             w_wrap;
   logic             w_inc_high;

   // Ratios 0 and 1 cannot form a high and a low phase, so they clamp to 2.
   assign w_req_ratio = (io_bus.i_div_ratio < c_MIN_DIV) ? c_MIN_DIV
                                                         : io_bus.i_div_ratio;
   assign w_half      = r_n >> 1;
   assign w_wrap      = (r_cnt == (r_n - c_ONE));
   // Never overflows: a non-wrap edge has r_cnt <= N-2.
   assign w_cnt_inc   = r_cnt + c_ONE;
   // Output is registered from the next count value so it changes on the
   // same edge as the counter.
   assign w_inc_high  = (w_cnt_inc < w_half);

   always_comb begin
      w_state_nxt  = r_state;
      w_n_nxt      = r_n;
      w_cnt_nxt    = r_cnt;
      w_shadow_nxt = r_shadow;
      w_out_nxt    = r_out;
      w_tick_nxt   = 1'b0;
      w_ack_nxt    = 1'b0;
      w_busy_nxt   = r_busy;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            w_out_nxt = 1'b0;
            // No period is running, so a new ratio can be applied directly.
            if (io_bus.i_cfg_req) begin
               w_n_nxt   = w_req_ratio;
               w_ack_nxt = 1'b1;
            end
            if (io_bus.i_enable) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
               w_out_nxt   = 1'b1;
               w_tick_nxt  = 1'b1;
            end
         end

         S_RUN: begin
            if (w_wrap) begin
               w_cnt_nxt = '0;
               if (!io_bus.i_enable) begin
                  w_state_nxt = S_IDLE;
                  w_out_nxt   = 1'b0;
                  // Stopping at this boundary: no later wrap will exist to
                  // apply a shadowed ratio, so apply it now as IDLE would.
                  if (io_bus.i_cfg_req) begin
                     w_n_nxt   = w_req_ratio;
                     w_ack_nxt = 1'b1;
                  end
               end else begin
                  w_out_nxt  = 1'b1;
                  w_tick_nxt = 1'b1;
                  // A request on the wrap edge waits one full old-ratio
                  // period before it is applied.
                  if (io_bus.i_cfg_req) begin
                     w_shadow_nxt = w_req_ratio;
                     w_busy_nxt   = 1'b1;
                     w_state_nxt  = S_PEND;
                  end
               end
            end else begin
               w_cnt_nxt = w_cnt_inc;
               w_out_nxt = w_inc_high;
               if (io_bus.i_cfg_req) begin
                  w_shadow_nxt = w_req_ratio;
                  w_busy_nxt   = 1'b1;
                  w_state_nxt  = S_PEND;
               end
            end
         end

         S_PEND: begin
            // Requests are ignored here; the shadow ratio is held.
            if (w_wrap) begin
               w_n_nxt    = r_shadow;
               w_ack_nxt  = 1'b1;
               w_busy_nxt = 1'b0;
               w_cnt_nxt  = '0;
               if (!io_bus.i_enable) begin
                  w_state_nxt = S_IDLE;
                  w_out_nxt   = 1'b0;
               end else begin
                  w_state_nxt = S_RUN;
                  w_out_nxt   = 1'b1;
                  w_tick_nxt  = 1'b1;
               end
            end else begin
               w_cnt_nxt = w_cnt_inc;
               w_out_nxt = w_inc_high;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_out_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_n      <= c_DEFAULT_DIV;
         r_cnt    <= '0;
         r_shadow <= '0;
         r_out    <= 1'b0;
         r_tick   <= 1'b0;
         r_ack    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_n      <= w_n_nxt;
         r_cnt    <= w_cnt_nxt;
         r_shadow <= w_shadow_nxt;
         r_out    <= w_out_nxt;
         r_tick   <= w_tick_nxt;
         r_ack    <= w_ack_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign io_bus.o_clk_div_out = r_out;
   assign io_bus.o_tick        = r_tick;
   assign io_bus.o_cfg_ack     = r_ack;
   assign io_bus.o_busy        = r_busy;

`ifdef CLK_DIV_EDGE_CNT_EN
   logic [15:0] r_edge_cnt;

   // Advances on the same edge that raises o_tick, so the count already
   // includes the tick currently visible on the output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_edge_cnt <= 16'd0;
      end else if (w_tick_nxt) begin
         r_edge_cnt <= r_edge_cnt + 16'd1;
      end
   end

   assign io_bus.o_edge_cnt = r_edge_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_ctrl
// Description : Directed self-checking bench for clk_div_ctrl. Expected
//               {clk_div_out, tick, cfg_ack, busy} values are queued before
//               each clock edge and compared one cycle later.
// Options     : CLK_DIV_EDGE_CNT_EN also checks the edge counter
// Revision    : 1.0  initial release
// ============================================================================
module tb_clk_div_ctrl;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   typedef struct {
      logic [3:0] v;
      string      tag;
   } exp_t;

   exp_t sb[$];

   clk_div_ctrl_if #(.DIV_W(8)) bus ();

   clk_div_ctrl #(
      .DIV_W       (8),
      .DEFAULT_DIV (2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic compare_head();
      exp_t       e;
      logic [3:0] obs;
      e   = sb.pop_front();
      obs = {bus.o_clk_div_out, bus.o_tick, bus.o_cfg_ack, bus.o_busy};
      n_tests++;
      assert (obs === e.v) else begin
         n_fail++;
         $error("FAIL %s: out/tick/ack/busy observed %b required %b",
                e.tag, obs, e.v);
      end
   endtask

   // Queue the expected outputs, advance one clock, then compare.
   task automatic cyc(input logic o, input logic t, input logic a,
                      input logic b, input string tag);
      exp_t e;
      e.v   = {o, t, a, b};
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_head();
   endtask

   // Compare without advancing the clock (used around asynchronous reset).
   task automatic check_now(input logic o, input logic t, input logic a,
                            input logic b, input string tag);
      exp_t e;
      e.v   = {o, t, a, b};
      e.tag = tag;
      sb.push_back(e);
      compare_head();
   endtask

   // One full divided period of ratio n with nothing pending.
   task automatic per(input int n, input logic ack0, input string tag);
      for (int i = 0; i < n; i++) begin
         cyc(i < n / 2, i == 0, ack0 && (i == 0), 1'b0,
             $sformatf("%s_c%0d", tag, i));
      end
   endtask

   initial begin
      n_tests            = 0;
      n_fail             = 0;
      reset              = 1'b1;
      bus.i_enable       = 1'b0;
      bus.i_cfg_req      = 1'b0;
      bus.i_div_ratio    = 8'd0;

      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      check_now(1'b0, 1'b0, 1'b0, 1'b0, "reset_state");
`ifdef CLK_DIV_EDGE_CNT_EN
      n_tests++;
      assert (bus.o_edge_cnt === 16'd0) else begin
         n_fail++;
         $error("FAIL edge_cnt_reset: observed %0d required 0", bus.o_edge_cnt);
      end
`endif
      @(negedge clk);
      reset = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle0");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle1");

      // Ratio 4 set while idle, then run: 1,1,0,0
      bus.i_div_ratio = 8'd4;
      bus.i_cfg_req   = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, "idle_cfg_ack");
      bus.i_cfg_req   = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle_after_ack");
      bus.i_enable    = 1'b1;
      per(4, 1'b0, "n4_p0");
      per(4, 1'b0, "n4_p1");

      // Update to 6 requested at cnt=1: old period completes first
      cyc(1'b1, 1'b1, 1'b0, 1'b0, "n4_p2_c0");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, "n4_p2_c1");
      bus.i_div_ratio = 8'd6;
      bus.i_cfg_req   = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "n4_p2_c2_busy");
      bus.i_cfg_req   = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "n4_p2_c3_busy");
      per(6, 1'b1, "n6_p0");
      per(6, 1'b0, "n6_p1");

      // Second request while busy is ignored; only ratio 3 is applied
      cyc(1'b1, 1'b1, 1'b0, 1'b0, "n6_p2_c0");
      bus.i_div_ratio = 8'd3;
      bus.i_cfg_req   = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b1, "n6_p2_c1");
      bus.i_div_ratio = 8'd10;
      cyc(1'b1, 1'b0, 1'b0, 1'b1, "n6_p2_c2_ignored");
      bus.i_cfg_req   = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "n6_p2_c3");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "n6_p2_c4");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "n6_p2_c5");
      per(3, 1'b1, "n3_p0");
      per(3, 1'b0, "n3_p1");

      // Ratio 1 requested on the wrap edge: one full ratio-3 period first
      bus.i_div_ratio = 8'd1;
      bus.i_cfg_req   = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b1, "r1_wrap_capture");
      bus.i_cfg_req   = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "r1_old_c1");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "r1_old_c2");
      per(2, 1'b1, "r1_n2_p0");
      per(2, 1'b0, "r1_n2_p1");

      // Ratio 0 clamps to 2
      cyc(1'b1, 1'b1, 1'b0, 1'b0, "r0_c0");
      bus.i_div_ratio = 8'd0;
      bus.i_cfg_req   = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "r0_c1_busy");
      bus.i_cfg_req   = 1'b0;
      per(2, 1'b1, "r0_n2_p0");
      per(2, 1'b0, "r0_n2_p1");

      // Ratio 5, enable dropped at cnt=1: period completes, then idle
      bus.i_div_ratio = 8'd5;
      bus.i_cfg_req   = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b1, "n5_set_c0");
      bus.i_cfg_req   = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "n5_set_c1");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, "n5_c0");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, "n5_c1");
      bus.i_enable    = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "n5_stop_c2");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "n5_stop_c3");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "n5_stop_c4");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "n5_idle0");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "n5_idle1");
      bus.i_enable    = 1'b1;
      per(5, 1'b0, "n5_reenable");

      // Enable dropped while an update is pending: it is applied and acked
      bus.i_div_ratio = 8'd4;
      bus.i_cfg_req   = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b1, "pstop_c0");
      bus.i_cfg_req   = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b1, "pstop_c1");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "pstop_c2");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "pstop_c3");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "pstop_c4");
      bus.i_enable    = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, "pstop_idle_ack");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "pstop_idle");
      bus.i_enable    = 1'b1;
      per(4, 1'b0, "pstop_n4_p0");
      per(4, 1'b0, "pstop_n4_p1");

      // Reset while pending at cnt=2: clears immediately, default ratio, no ack
      cyc(1'b1, 1'b1, 1'b0, 1'b0, "rst_c0");
      bus.i_div_ratio = 8'd7;
      bus.i_cfg_req   = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b1, "rst_c1");
      bus.i_cfg_req   = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "rst_c2");
      reset = 1'b1;
      #1;
      check_now(1'b0, 1'b0, 1'b0, 1'b0, "async_reset");
`ifdef CLK_DIV_EDGE_CNT_EN
      n_tests++;
      assert (bus.o_edge_cnt === 16'd0) else begin
         n_fail++;
         $error("FAIL edge_cnt_async_reset: observed %0d required 0",
                bus.o_edge_cnt);
      end
`endif
      @(negedge clk);
      reset = 1'b0;
      for (int p = 0; p < 10; p++) begin
         per(2, 1'b0, $sformatf("post_rst_p%0d", p));
      end
`ifdef CLK_DIV_EDGE_CNT_EN
      n_tests++;
      assert (bus.o_edge_cnt === 16'd10) else begin
         n_fail++;
         $error("FAIL edge_cnt_10: observed %0d required 10", bus.o_edge_cnt);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
